// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle sequencer and the MIPS-style datapath.
// master = sequencer side, slave = datapath side.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] functcode;
    logic       alu_zero;
    logic       alu_lez;
    logic       v_flag;
    logic       mem_ready;

    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [2:0] state;
    logic       illegal;
    logic       instr_done;

    modport master (
        input  opcode, functcode, alu_zero, alu_lez, v_flag, mem_ready,
        output pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg, state,
               illegal, instr_done
    );

    modport slave (
        output opcode, functcode, alu_zero, alu_lez, v_flag, mem_ready,
        input  pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg, state,
               illegal, instr_done
    );
endinterface

// File: rtl/multicycle_control.sv
// Fetch/decode/execute/memory/writeback sequencer for the shared-resource MIPS datapath.
// Define CUSTOM_OPS_EN to decode the extended set (brv, jmxor, blezal, balv, jalpc, nandi).
module multicycle_control (
    input logic                   clk,
    input logic                   rst,
    multicycle_control_if.master  bus
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        KRtype, KBrv, KJmxor, KLw, KSw, KBeq, KNandi, KBlezal, KBalv, KJalpc, KIllegal
    } kind_e;

    state_e     state_q, state_d;
    logic [5:0] op_q, fn_q;
    kind_e      dec_kind, cur_kind;

    function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
        kind_e k;
        case (op)
            6'b000000: begin
`ifdef CUSTOM_OPS_EN
                if (fn == 6'b010100)      k = KBrv;
                else if (fn == 6'b100010) k = KJmxor;
                else                      k = KRtype;
`else
                k = (fn == fn) ? KRtype : KRtype;
`endif
            end
            6'b100011: k = KLw;
            6'b101011: k = KSw;
            6'b000100: k = KBeq;
`ifdef CUSTOM_OPS_EN
            6'b010000: k = KNandi;
            6'b100100: k = KBlezal;
            6'b100000: k = KBalv;
            6'b011111: k = KJalpc;
`endif
            default:   k = KIllegal;
        endcase
        return k;
    endfunction

    // DECODE acts on the live IR fields; later states use the latched copy.
    assign dec_kind = classify(bus.opcode, bus.functcode);
    assign cur_kind = classify(op_q, fn_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            op_q    <= 6'd0;
            fn_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                op_q <= bus.opcode;
                fn_q <= bus.functcode;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                if (dec_kind == KIllegal)     state_d = StFetch;
                else if (dec_kind == KJalpc)  state_d = StWb;
                else                          state_d = StExec;
            end
            StExec: begin
                case (cur_kind)
                    KRtype, KNandi:    state_d = StWb;
                    KJmxor, KLw, KSw:  state_d = StMem;
                    KBlezal:           state_d = bus.alu_lez ? StWb : StFetch;
                    KBalv:             state_d = bus.v_flag ? StWb : StFetch;
                    default:           state_d = StFetch;
                endcase
            end
            StMem:    if (bus.mem_ready) state_d = (cur_kind == KSw) ? StFetch : StWb;
            StWb:     state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write;
    logic       alu_src_a, illegal, instr_done;
    logic [1:0] alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg;

    // Every strobe is forced low while reset is held so an aborted write cannot leak out.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        illegal       = 1'b0;
        instr_done    = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StFetch: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = bus.mem_ready;
                    pc_write  = bus.mem_ready;
                end
                StDecode: begin
                    alu_src_b = 2'b11;
                    illegal   = (dec_kind == KIllegal);
                end
                StExec: begin
                    case (cur_kind)
                        KRtype, KJmxor: begin
                            alu_src_a = 1'b1;
                            alu_op    = 2'b10;
                        end
                        KBrv: begin
                            pc_source  = 2'b10;
                            pc_write   = bus.v_flag;
                            instr_done = 1'b1;
                        end
                        KLw, KSw: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'b10;
                        end
                        KNandi: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'b10;
                            alu_op    = 2'b11;
                        end
                        KBeq: begin
                            alu_src_a     = 1'b1;
                            alu_op        = 2'b01;
                            pc_source     = 2'b01;
                            pc_write_cond = 1'b1;
                            instr_done    = 1'b1;
                        end
                        KBlezal:  instr_done = !bus.alu_lez;
                        KBalv:    instr_done = !bus.v_flag;
                        default: ;
                    endcase
                end
                StMem: begin
                    iord = 1'b1;
                    if (cur_kind == KSw) begin
                        mem_write  = 1'b1;
                        instr_done = bus.mem_ready;
                    end else begin
                        mem_read = 1'b1;
                    end
                end
                StWb: begin
                    instr_done = 1'b1;
                    case (cur_kind)
                        KRtype: begin
                            reg_write = 1'b1;
                            reg_dst   = 2'b01;
                        end
                        KNandi:   reg_write = 1'b1;
                        KLw: begin
                            reg_write  = 1'b1;
                            mem_to_reg = 2'b01;
                        end
                        KBlezal, KBalv, KJalpc, KJmxor: begin
                            reg_write  = 1'b1;
                            reg_dst    = 2'b10;
                            mem_to_reg = 2'b10;
                            pc_write   = 1'b1;
                            pc_source  = (cur_kind == KJalpc) ? 2'b00 :
                                         (cur_kind == KJmxor) ? 2'b11 : 2'b01;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_write      = pc_write;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.ir_write      = ir_write;
    assign bus.iord          = iord;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.reg_write     = reg_write;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = alu_op;
    assign bus.pc_source     = pc_source;
    assign bus.reg_dst       = reg_dst;
    assign bus.mem_to_reg    = mem_to_reg;
    assign bus.illegal       = illegal;
    assign bus.instr_done    = instr_done;
    assign bus.state         = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed cases then random instructions,
// each checked cycle by cycle against an expected-trace model built from the instruction rules.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst;
    multicycle_control_if bus();

    multicycle_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source, reg_dst, mem_to_reg;
        logic [2:0] state;
        logic       illegal, instr_done;
    } step_t;

    localparam int KR = 0, KBRV = 1, KJMX = 2, KLW = 3, KSW = 4, KBEQ = 5;
    localparam int KNANDI = 6, KBLEZ = 7, KBALV = 8, KJALPC = 9, KILL = 10;

    int checks = 0;
    int failures = 0;

    step_t exp_q[$];
    logic  rdy_q[$];
    logic  keep_q[$];

    task automatic check(input string tag, input step_t exp);
        step_t obs;
        obs = '0;
        obs.pc_write      = bus.pc_write;
        obs.pc_write_cond = bus.pc_write_cond;
        obs.ir_write      = bus.ir_write;
        obs.iord          = bus.iord;
        obs.mem_read      = bus.mem_read;
        obs.mem_write     = bus.mem_write;
        obs.reg_write     = bus.reg_write;
        obs.alu_src_a     = bus.alu_src_a;
        obs.alu_src_b     = bus.alu_src_b;
        obs.alu_op        = bus.alu_op;
        obs.pc_source     = bus.pc_source;
        obs.reg_dst       = bus.reg_dst;
        obs.mem_to_reg    = bus.mem_to_reg;
        obs.state         = bus.state;
        obs.illegal       = bus.illegal;
        obs.instr_done    = bus.instr_done;
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Kind actually executed once the build configuration is taken into account.
    function automatic int eff(input int k);
`ifdef CUSTOM_OPS_EN
        return k;
`else
        if (k == KBRV || k == KJMX) return KR;
        if (k >= KNANDI && k <= KJALPC) return KILL;
        return k;
`endif
    endfunction

    function automatic logic is_legal_op(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b010000, 6'b100100, 6'b100000, 6'b011111};
    endfunction

    task automatic push(input step_t s, input logic rdy, input logic keep);
        exp_q.push_back(s);
        rdy_q.push_back(rdy);
        keep_q.push_back(keep);
    endtask

    // Expected per-cycle trace of one instruction, from the phase rules.
    task automatic build(input int k, input logic lez, input logic v, input int fst, input int mst);
        step_t s;
        logic  go_wb, go_mem;
        go_wb  = 1'b0;
        go_mem = 1'b0;
        s = '0; s.mem_read = 1'b1; s.alu_src_b = 2'b01;
        repeat (fst) push(s, 1'b0, 1'b1);
        s.ir_write = 1'b1; s.pc_write = 1'b1;
        push(s, 1'b1, 1'b1);
        s = '0; s.state = 3'd1; s.alu_src_b = 2'b11;
        if (k == KILL) begin
            s.illegal = 1'b1;
            push(s, 1'($urandom), 1'b1);
            return;
        end
        push(s, 1'($urandom), 1'b1);
        if (k == KJALPC) go_wb = 1'b1;
        else begin
            s = '0; s.state = 3'd2;
            case (k)
                KR:     begin s.alu_src_a = 1'b1; s.alu_op = 2'b10; go_wb = 1'b1; end
                KJMX:   begin s.alu_src_a = 1'b1; s.alu_op = 2'b10; go_mem = 1'b1; end
                KBRV:   begin s.pc_source = 2'b10; s.pc_write = v; s.instr_done = 1'b1; end
                KLW, KSW: begin s.alu_src_a = 1'b1; s.alu_src_b = 2'b10; go_mem = 1'b1; end
                KNANDI: begin
                    s.alu_src_a = 1'b1; s.alu_src_b = 2'b10; s.alu_op = 2'b11; go_wb = 1'b1;
                end
                KBEQ:   begin
                    s.alu_src_a = 1'b1; s.alu_op = 2'b01; s.pc_source = 2'b01;
                    s.pc_write_cond = 1'b1; s.instr_done = 1'b1;
                end
                KBLEZ:  begin go_wb = lez; s.instr_done = !lez; end
                KBALV:  begin go_wb = v; s.instr_done = !v; end
                default: ;
            endcase
            push(s, 1'($urandom), 1'b0);
        end
        if (go_mem) begin
            s = '0; s.state = 3'd3; s.iord = 1'b1;
            if (k == KSW) s.mem_write = 1'b1; else s.mem_read = 1'b1;
            repeat (mst) push(s, 1'b0, 1'b0);
            if (k == KSW) s.instr_done = 1'b1; else go_wb = 1'b1;
            push(s, 1'b1, 1'b0);
        end
        if (go_wb) begin
            s = '0; s.state = 3'd4; s.instr_done = 1'b1; s.reg_write = 1'b1;
            case (k)
                KR:     s.reg_dst = 2'b01;
                KLW:    s.mem_to_reg = 2'b01;
                KNANDI: ;
                default: begin
                    s.reg_dst = 2'b10; s.mem_to_reg = 2'b10; s.pc_write = 1'b1;
                    s.pc_source = (k == KJALPC) ? 2'b00 : (k == KJMX) ? 2'b11 : 2'b01;
                end
            endcase
            push(s, 1'($urandom), 1'b0);
        end
    endtask

    // Runs one instruction; entered and left just after a rising edge in FETCH.
    task automatic run_instr(input string tag, input int kind, input logic [5:0] op_in,
                             input logic z, input logic lez, input logic v,
                             input int fst, input int mst);
        logic [5:0] op, fn;
        int         n;
        fn = 6'($urandom);
        case (kind)
            KR: begin
                op = 6'b000000;
                while (fn == 6'b010100 || fn == 6'b100010) fn = 6'($urandom);
            end
            KBRV:   begin op = 6'b000000; fn = 6'b010100; end
            KJMX:   begin op = 6'b000000; fn = 6'b100010; end
            KLW:    op = 6'b100011;
            KSW:    op = 6'b101011;
            KBEQ:   op = 6'b000100;
            KNANDI: op = 6'b010000;
            KBLEZ:  op = 6'b100100;
            KBALV:  op = 6'b100000;
            KJALPC: op = 6'b011111;
            default: op = op_in;
        endcase
        exp_q.delete(); rdy_q.delete(); keep_q.delete();
        build(eff(kind), lez, v, fst, mst);
        n = exp_q.size();
        bus.alu_zero = z;
        bus.alu_lez  = lez;
        bus.v_flag   = v;
        for (int i = 0; i < n; i++) begin
            bus.mem_ready = rdy_q[i];
            if (keep_q[i]) begin
                bus.opcode    = op;
                bus.functcode = fn;
            end else begin
                bus.opcode    = 6'($urandom);
                bus.functcode = 6'($urandom);
            end
            @(negedge clk);
            check($sformatf("%s_k%0d_c%0d", tag, kind, i), exp_q[i]);
            @(posedge clk);
            #1;
        end
    endtask

    step_t zero_s, fetch_s, exec_r;

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_s  = '0;
        fetch_s = '0; fetch_s.mem_read = 1'b1; fetch_s.alu_src_b = 2'b01;
        exec_r  = '0; exec_r.state = 3'd2; exec_r.alu_src_a = 1'b1; exec_r.alu_op = 2'b10;

        rst = 1'b1;
        bus.opcode = '0; bus.functcode = '0; bus.alu_zero = 1'b0; bus.alu_lez = 1'b0;
        bus.v_flag = 1'b0; bus.mem_ready = 1'b1;
        #1 check("reset_outputs", zero_s);
        @(posedge clk); @(negedge clk);
        check("reset_held", zero_s);
        @(posedge clk); #1;
        rst = 1'b0; bus.mem_ready = 1'b0;
        #1 check("reset_release", fetch_s);
        @(posedge clk); #1;

        // Reset mid-EXEC of an R-format add.
        bus.opcode = 6'b000000; bus.functcode = 6'b100000; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("exec_before_rst", exec_r);
        rst = 1'b1;
        #1 check("rst_mid_exec", zero_s);
        @(posedge clk); #1;
        check("rst_mid_exec_held", zero_s);
        rst = 1'b0; bus.mem_ready = 1'b0;
        #1 check("rst_mid_exec_release", fetch_s);
        @(posedge clk); #1;

        run_instr("radd",        KR,     6'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr("lw_stall",    KLW,    6'd0, 1'b0, 1'b0, 1'b0, 0, 3);
        run_instr("beq_taken",   KBEQ,   6'd0, 1'b1, 1'b0, 1'b0, 0, 0);
        run_instr("beq_not",     KBEQ,   6'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr("blezal_t",    KBLEZ,  6'd0, 1'b0, 1'b1, 1'b0, 0, 0);
        run_instr("blezal_n",    KBLEZ,  6'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr("illegal_3f",  KILL,   6'b111111, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr("jalpc",       KJALPC, 6'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr("sw_stall",    KSW,    6'd0, 1'b0, 1'b0, 1'b0, 2, 2);
        run_instr("jmxor",       KJMX,   6'd0, 1'b0, 1'b0, 1'b0, 1, 1);
        run_instr("brv_v",       KBRV,   6'd0, 1'b0, 1'b0, 1'b1, 0, 0);
        run_instr("balv_v",      KBALV,  6'd0, 1'b0, 1'b0, 1'b1, 0, 0);
        run_instr("nandi",       KNANDI, 6'd0, 1'b0, 1'b0, 1'b0, 0, 0);

        for (int t = 0; t < 250; t++) begin
            int         k;
            logic [5:0] iop;
            k   = int'($urandom_range(0, 10));
            iop = 6'($urandom);
            while (is_legal_op(iop)) iop = 6'($urandom);
            run_instr("rand", k, iop, 1'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
